riscv_v_bw_reduct_ctrl: RTL and testbench

- Multi-cycle sequencer for vector bitwise reductions (vredand/vredor/vredxor) over a register group of 1-8 chunks.
- Streams chunks from the vector register file and drives the combinational bitwise logic unit.
- First folds the chunks element-wise into an accumulator, then performs the intra-vector reduction, then combines the result with the scalar operand.
- Sits between the vector issue stage and the bitwise ALU slice.

---
 rtl/riscv_v_pkg.sv | 55 +++++
 rtl/riscv_v_bw_reduct_operand_mux.sv | 78 +++++++
 rtl/riscv_v_bw_reduct_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_riscv_v_bw_reduct_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_v_pkg.sv
// Shared types and helpers for the vector bitwise-reduction sequencer.
//   bw_reduct_op_e     : reduction operator (AND / OR / XOR)
//   bw_reduct_state_e  : sequencer state encoding (also visible on dbg_state)
//   decode_op          : maps the 2-bit request opcode, folding the illegal code 3 onto XOR
//   bw_identity        : 64-bit identity fill for an operator (replicated to chunk width)
//   osize_to_vector    : one-hot element-size select for the bitwise unit
//   osize_mask         : low-bit mask covering one element of the given size
package riscv_v_pkg;

  typedef enum logic [1:0] {
    BW_AND = 2'd0,
    BW_OR  = 2'd1,
    BW_XOR = 2'd2
  } bw_reduct_op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    FOLD   = 3'd2,
    REDUCE = 3'd3,
    FINAL  = 3'd4,
    DONE   = 3'd5
  } bw_reduct_state_e;

  function automatic bw_reduct_op_e decode_op(input logic [1:0] op);
    bw_reduct_op_e r;
    case (op)
      2'd0:    r = BW_AND;
      2'd1:    r = BW_OR;
      default: r = BW_XOR;
    endcase
    return r;
  endfunction

  // Every chunk width is a multiple of 64, so a 64-bit pattern replicates cleanly.
  function automatic logic [63:0] bw_identity(input bw_reduct_op_e op);
    return (op == BW_AND) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
  endfunction

  function automatic logic [3:0] osize_to_vector(input logic [1:0] osize);
    return 4'b0001 << osize;
  endfunction

  function automatic logic [63:0] osize_mask(input logic [1:0] osize);
    logic [63:0] m;
    case (osize)
      2'd0:    m = 64'h0000_0000_0000_00FF;
      2'd1:    m = 64'h0000_0000_0000_FFFF;
      2'd2:    m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/riscv_v_bw_reduct_operand_mux.sv
// Combinational operand builder for the bitwise unit.
//   state   : current sequencer state (bw_reduct_state_e encoding)
//   op      : latched operator (bw_reduct_op_e encoding)
//   osize   : latched element size (0=8b .. 3=64b)
//   acc     : accumulator
//   rd_data : chunk returned by the register file
//   scalar  : latched vs1[0]
//   rd_mask : per-byte active mask (only with RISCV_V_BW_REDUCT_MASK_EN)
//   srca/srcb : operands; zero in states that do not use the unit
// FOLD   : acc  OP chunk (inactive bytes replaced by the identity byte)
// REDUCE : acc  OP identity fill, unit reduces across elements
// FINAL  : {identity, scalar elem0} OP acc
module riscv_v_bw_reduct_operand_mux
  import riscv_v_pkg::*;
#(
  parameter int DATA_WIDTH = 128
) (
  input  logic [2:0]              state,
  input  logic [1:0]              op,
  input  logic [1:0]              osize,
  input  logic [DATA_WIDTH-1:0]   acc,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  input  logic [63:0]             scalar,
`ifdef RISCV_V_BW_REDUCT_MASK_EN
  input  logic [DATA_WIDTH/8-1:0] rd_mask,
`endif
  output logic [DATA_WIDTH-1:0]   srca,
  output logic [DATA_WIDTH-1:0]   srcb
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] ident;
  logic [DATA_WIDTH-1:0] elem0_vec;
  logic [DATA_WIDTH-1:0] data_eff;
  int                    ebytes;

  always_comb begin
    ident     = {(DATA_WIDTH/64){bw_identity(bw_reduct_op_e'(op))}};
    ebytes    = 32'sd1 << osize;

    // Scalar occupies element 0 only; the rest must not disturb the result.
    elem0_vec = ident;
    for (int b = 0; b < 8; b++) begin
      if (b < ebytes) elem0_vec[8*b +: 8] = scalar[8*b +: 8];
    end

    data_eff = rd_data;
`ifdef RISCV_V_BW_REDUCT_MASK_EN
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (!rd_mask[b]) data_eff[8*b +: 8] = ident[8*b +: 8];
    end
`endif

    srca = '0;
    srcb = '0;
    case (state)
      FOLD: begin
        srca = acc;
        srcb = data_eff;
      end
      REDUCE: begin
        srca = acc;
        srcb = ident;
      end
      FINAL: begin
        srca = elem0_vec;
        srcb = acc;
      end
      default: ;
    endcase
  end

  // NUM_BYTES only sizes the optional mask loop.
  logic unused_nb;
  assign unused_nb = (NUM_BYTES == 0);

endmodule

// File: rtl/riscv_v_bw_reduct_ctrl.sv
// Sequencer for vredand / vredor / vredxor over a 1..MAX_CHUNKS register group.
// Streams chunks from the register file, folds them element-wise into an
// accumulator through the external combinational bitwise unit, reduces the
// accumulator across elements, then combines with the scalar operand.
// Optional feature macro: RISCV_V_BW_REDUCT_MASK_EN (adds per-byte rd_mask).
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid/req_ready   : request handshake (req_ready high only when idle)
//   req_op/osize/num_chunks/scalar : request payload, latched on acceptance
//   rd_valid/rd_ready/rd_idx       : chunk read request handshake
//   rd_data_valid/rd_data(/rd_mask): read return (only consumed in FOLD)
//   bw_*                  : bitwise unit controls/operands, zero when unit idle
//   bw_result             : unit result, same cycle
//   res_valid/res_ready/res_data   : scalar result handshake
//   flush                 : abort the current operation
//   dbg_state             : current state encoding
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; the valid side holds its payload stable until then.
module riscv_v_bw_reduct_ctrl
  import riscv_v_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int MAX_CHUNKS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [1:0]              req_osize,
  input  logic [3:0]              req_num_chunks,
  input  logic [63:0]             req_scalar,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [2:0]              rd_idx,
  input  logic                    rd_data_valid,
`ifdef RISCV_V_BW_REDUCT_MASK_EN
  input  logic [DATA_WIDTH/8-1:0] rd_mask,
`endif
  input  logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    bw_is_and,
  output logic                    bw_is_or,
  output logic                    bw_is_xor,
  output logic                    bw_is_reduct,
  output logic [3:0]              bw_osize_vector,
  output logic [DATA_WIDTH-1:0]   bw_srca,
  output logic [DATA_WIDTH-1:0]   bw_srcb,
  input  logic [DATA_WIDTH-1:0]   bw_result,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [63:0]             res_data,
  input  logic                    flush,
  output logic [2:0]              dbg_state
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam logic [3:0] MAX_N = 4'(MAX_CHUNKS);

  bw_reduct_state_e      state;
  bw_reduct_op_e         op_q;
  logic [1:0]            osize_q;
  logic [2:0]            last_q;
  logic [63:0]           scalar_q;
  logic [DATA_WIDTH-1:0] acc;
  logic [2:0]            cnt;

  bw_reduct_op_e         req_op_e;
  logic [3:0]            n_minus_1;
  logic                  fold_data;
  logic                  unit_active;
  logic [DATA_WIDTH-1:0] mux_a;
  logic [DATA_WIDTH-1:0] mux_b;

  assign req_op_e  = decode_op(req_op);
  // Out-of-range lengths collapse to a single chunk (last index 0).
  assign n_minus_1 = (req_num_chunks == 4'd0 || req_num_chunks > MAX_N) ? 4'd0
                                                                        : req_num_chunks - 4'd1;

  assign fold_data   = (state == FOLD) && rd_data_valid;
  assign unit_active = fold_data || (state == REDUCE) || (state == FINAL);

  riscv_v_bw_reduct_operand_mux #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mux (
    .state   (state),
    .op      (op_q),
    .osize   (osize_q),
    .acc     (acc),
    .rd_data (rd_data),
    .scalar  (scalar_q),
`ifdef RISCV_V_BW_REDUCT_MASK_EN
    .rd_mask (rd_mask),
`endif
    .srca    (mux_a),
    .srcb    (mux_b)
  );

  assign bw_srca         = unit_active ? mux_a : '0;
  assign bw_srcb         = unit_active ? mux_b : '0;
  assign bw_is_and       = unit_active && (op_q == BW_AND);
  assign bw_is_or        = unit_active && (op_q == BW_OR);
  assign bw_is_xor       = unit_active && (op_q == BW_XOR);
  assign bw_is_reduct    = (state == REDUCE);
  assign bw_osize_vector = unit_active ? osize_to_vector(osize_q) : 4'b0000;

  assign rd_idx    = cnt;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= BW_AND;
      osize_q   <= 2'd0;
      last_q    <= 3'd0;
      scalar_q  <= 64'd0;
      acc       <= '0;
      cnt       <= 3'd0;
      req_ready <= 1'b1;
      rd_valid  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= 64'd0;
    end else if (flush && state != IDLE) begin
      // Abort: any read return arriving this cycle is dropped with the state.
      state     <= IDLE;
      req_ready <= 1'b1;
      rd_valid  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= req_op_e;
            osize_q   <= req_osize;
            last_q    <= n_minus_1[2:0];
            scalar_q  <= req_scalar;
            acc       <= {(DATA_WIDTH/64){bw_identity(req_op_e)}};
            cnt       <= 3'd0;
            req_ready <= 1'b0;
            rd_valid  <= 1'b1;
            state     <= READ;
          end
        end
        READ: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            state    <= FOLD;
          end
        end
        FOLD: begin
          if (rd_data_valid) begin
            acc <= bw_result;
            cnt <= cnt + 3'd1;
            if (cnt == last_q) begin
              state <= REDUCE;
            end else begin
              rd_valid <= 1'b1;
              state    <= READ;
            end
          end
        end
        REDUCE: begin
          acc   <= bw_result;
          state <= FINAL;
        end
        FINAL: begin
          res_data  <= bw_result[63:0] & osize_mask(osize_q);
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rd_valid  <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

  // NUM_BYTES documents the mask width; referenced so the build stays lint-clean.
  logic unused_nb;
  assign unused_nb = (NUM_BYTES == 0);

endmodule

// File: tb/tb_riscv_v_bw_reduct_ctrl.sv
// Bench for riscv_v_bw_reduct_ctrl: table-driven directed vectors, hand-written
// flush / reset sequences, and randomized requests checked against a
// element-level reference reduction.
module tb_riscv_v_bw_reduct_ctrl;

  localparam int DW = 128;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [1:0]    req_osize;
  logic [3:0]    req_num_chunks;
  logic [63:0]   req_scalar;
  logic          rd_valid;
  logic          rd_ready;
  logic [2:0]    rd_idx;
  logic          rd_data_valid;
  logic [DW-1:0] rd_data;
  logic          bw_is_and, bw_is_or, bw_is_xor, bw_is_reduct;
  logic [3:0]    bw_osize_vector;
  logic [DW-1:0] bw_srca, bw_srcb, bw_result;
  logic          res_valid;
  logic          res_ready;
  logic [63:0]   res_data;
  logic          flush;
  logic [2:0]    dbg_state;
`ifdef RISCV_V_BW_REDUCT_MASK_EN
  logic [NB-1:0] rd_mask = '1;
`endif

  riscv_v_bw_reduct_ctrl #(.DATA_WIDTH(DW), .MAX_CHUNKS(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_osize       (req_osize),
    .req_num_chunks  (req_num_chunks),
    .req_scalar      (req_scalar),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .rd_idx          (rd_idx),
    .rd_data_valid   (rd_data_valid),
`ifdef RISCV_V_BW_REDUCT_MASK_EN
    .rd_mask         (rd_mask),
`endif
    .rd_data         (rd_data),
    .bw_is_and       (bw_is_and),
    .bw_is_or        (bw_is_or),
    .bw_is_xor       (bw_is_xor),
    .bw_is_reduct    (bw_is_reduct),
    .bw_osize_vector (bw_osize_vector),
    .bw_srca         (bw_srca),
    .bw_srcb         (bw_srcb),
    .bw_result       (bw_result),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .flush           (flush),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bitwise unit model ----------------
  function automatic logic [DW-1:0] unit_reduce(input logic [DW-1:0] t, input logic [3:0] ov,
                                                input int kind);
    int esz;
    logic [63:0] emask, a, v;
    esz   = ov[0] ? 8 : ov[1] ? 16 : ov[2] ? 32 : 64;
    emask = (esz == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << esz) - 64'd1);
    a     = t[63:0] & emask;
    for (int e = 1; e < DW / esz; e++) begin
      v = 64'(t >> (e * esz)) & emask;
      if (kind == 0) a = a & v;
      else if (kind == 1) a = a | v;
      else a = a ^ v;
    end
    return DW'(a);
  endfunction

  always_comb begin
    logic [DW-1:0] t;
    int kind;
    t    = '0;
    kind = 2;
    if (bw_is_and) begin t = bw_srca & bw_srcb; kind = 0; end
    else if (bw_is_or) begin t = bw_srca | bw_srcb; kind = 1; end
    else if (bw_is_xor) begin t = bw_srca ^ bw_srcb; kind = 2; end
    bw_result = bw_is_reduct ? unit_reduce(t, bw_osize_vector, kind) : t;
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] chunk_mem [8];

  // Reduction of every element of the first n chunks plus the scalar element.
  function automatic logic [63:0] ref_reduce(input int op, input int osize, input int n,
                                             input logic [63:0] scalar);
    int esz;
    logic [63:0] emask, a, v;
    esz   = 8 << osize;
    emask = (esz == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << esz) - 64'd1);
    a     = (op == 0) ? emask : 64'd0;
    for (int c = 0; c <= n; c++) begin
      for (int e = 0; e < DW / esz; e++) begin
        v = (c == n) ? ((e == 0) ? (scalar & emask) : ((op == 0) ? emask : 64'd0))
                     : (64'(chunk_mem[c] >> (e * esz)) & emask);
        if (op == 0) a = a & v;
        else if (op == 1) a = a | v;
        else a = a ^ v;
      end
    end
    return a;
  endfunction

  task automatic fill_chunks(input int kind);
    logic [DW-1:0] x;
    for (int i = 0; i < 8; i++) begin
      case (kind)
        0: for (int b = 0; b < NB; b++) x[8*b +: 8] = 8'(b + 1);
        1: begin
          x = '1;
          if (i == 1) x[95:64] = 32'h0F0F_0F0F;
        end
        2: x = DW'(1) << (i * 17);
        3: x = {$urandom, $urandom, $urandom, $urandom};
        default: x = ~({$urandom, $urandom, $urandom, $urandom} &
                       {$urandom, $urandom, $urandom, $urandom} &
                       {$urandom, $urandom, $urandom, $urandom});
      endcase
      chunk_mem[i] = x;
    end
  endtask

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_read(input int i, input int rdy_d, input int data_d, input logic flush_on_data);
    int guard;
    guard = 0;
    while (!rd_valid && guard < 40) begin @(negedge clk); guard++; end
    check("rd_valid_rise", rd_valid, 1);
    check("rd_idx", rd_idx, i);
    for (int d = 0; d < rdy_d; d++) begin
      check("rd_valid_held", rd_valid, 1);
      rd_data_valid = 1'b1;                   // stray return while reading; must be ignored
      rd_data       = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    rd_data_valid = 1'b0;
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    for (int d = 0; d < data_d; d++) begin
      check("no_extra_read", rd_valid, 0);
      check("bw_quiet_wait", {bw_is_and, bw_is_or, bw_is_xor}, 0);
      @(negedge clk);
    end
    rd_data_valid = 1'b1;
    rd_data       = chunk_mem[i];
    flush         = flush_on_data;
    #1;
    check("fold_srcb", bw_srcb, chunk_mem[i]);
    check("fold_not_reduct", bw_is_reduct, 0);
    @(negedge clk);
    rd_data_valid = 1'b0;
    flush         = 1'b0;
    rd_data       = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic accept_req(input logic [1:0] op, input logic [1:0] osize, input logic [3:0] n,
                            input logic [63:0] scalar, output int t0);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_osize = osize;
    req_num_chunks = n; req_scalar = scalar;
    t0 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 2'($urandom); req_osize = 2'($urandom);
    req_num_chunks = 4'($urandom); req_scalar = {$urandom, $urandom};
    check("req_ready_busy", req_ready, 0);
  endtask

  task automatic run_txn(input logic [1:0] op, input logic [1:0] osize, input logic [3:0] n_raw,
                         input logic [63:0] scalar, input int rdy_d, input int data_d,
                         input int res_d, input logic use_exp, input logic [63:0] exp_const);
    int n_eff, guard, t0, lat;
    logic [63:0] expv;
    n_eff = (n_raw == 0 || n_raw > 8) ? 1 : int'(n_raw);
    exp_q.push_back(use_exp ? exp_const : ref_reduce(int'(op), int'(osize), n_eff, scalar));
    accept_req(op, osize, n_raw, scalar, t0);
    for (int i = 0; i < n_eff; i++) do_read(i, rdy_d, data_d, 1'b0);
    guard = 0;
    while (!res_valid && guard < 40) begin @(negedge clk); guard++; end
    check("res_valid_rise", res_valid, 1);
    lat = cyc - t0;
    check("latency", lat, 2 * n_eff + 3 + n_eff * (rdy_d + data_d));
    expv = exp_q.pop_front();
    check("res_data", res_data, expv);
    for (int d = 0; d < res_d; d++) begin
      @(negedge clk);
      check("res_valid_hold", res_valid, 1);
      check("res_data_hold", res_data, expv);
      check("req_ready_done", req_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("res_valid_drop", res_valid, 0);
    check("req_ready_back", req_ready, 1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [1:0]  op;
    logic [1:0]  osize;
    logic [3:0]  n;
    logic [63:0] scalar;
    int          kind;
    int          rdy_d;
    int          data_d;
    int          res_d;
    logic        use_exp;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int t0;
    tbl[0] = '{2'd2, 2'd0, 4'd1, 64'h0,         0, 0, 0, 0, 1'b1, 64'h10};
    tbl[1] = '{2'd0, 2'd2, 4'd2, 64'hFFFF_FFFF, 1, 0, 0, 0, 1'b1, 64'h0F0F_0F0F};
    tbl[2] = '{2'd1, 2'd3, 4'd8, 64'h100,       2, 0, 0, 0, 1'b1, 64'h0088_0044_0022_0111};
    tbl[3] = '{2'd2, 2'd0, 4'd1, 64'h0,         0, 3, 4, 0, 1'b1, 64'h10};
    tbl[4] = '{2'd0, 2'd2, 4'd2, 64'hFFFF_FFFF, 1, 0, 0, 5, 1'b1, 64'h0F0F_0F0F};
    tbl[5] = '{2'd3, 2'd1, 4'd3, 64'h1234_5678_9ABC_DEF0, 3, 1, 1, 1, 1'b0, 64'h0};
    tbl[6] = '{2'd1, 2'd2, 4'd0, 64'hA5A5_0000_5A5A_0F0F, 3, 0, 0, 0, 1'b0, 64'h0};
    tbl[7] = '{2'd0, 2'd0, 4'd12, 64'hFFFF_FFFF_FFFF_FFF7, 4, 0, 0, 0, 1'b0, 64'h0};

    rst = 1'b1; req_valid = 0; req_op = 0; req_osize = 0; req_num_chunks = 0; req_scalar = 0;
    rd_ready = 0; rd_data_valid = 0; rd_data = '0; res_ready = 0; flush = 0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_bw_ctrl", {bw_is_and, bw_is_or, bw_is_xor, bw_is_reduct, bw_osize_vector}, 0);
    check("rst_bw_srca", bw_srca, 0);
    check("rst_bw_srcb", bw_srcb, 0);
    check("rst_state", dbg_state, riscv_v_pkg::IDLE);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors.
    for (int v = 0; v < 8; v++) begin
      fill_chunks(tbl[v].kind);
      run_txn(tbl[v].op, tbl[v].osize, tbl[v].n, tbl[v].scalar, tbl[v].rdy_d,
              tbl[v].data_d, tbl[v].res_d, tbl[v].use_exp, tbl[v].exp);
    end

    // Flush while chunk 2 of 4 is being folded.
    fill_chunks(3);
    accept_req(2'd1, 2'd3, 4'd4, 64'h55, t0);
    do_read(0, 0, 0, 1'b0);
    do_read(1, 0, 0, 1'b0);
    do_read(2, 0, 1, 1'b1);
    check("flush_state", dbg_state, riscv_v_pkg::IDLE);
    check("flush_rd_valid", rd_valid, 0);
    check("flush_req_ready", req_ready, 1);
    for (int d = 0; d < 8; d++) begin
      check("flush_no_result", res_valid, 0);
      @(negedge clk);
    end
    fill_chunks(3);
    run_txn(2'd2, 2'd2, 4'd4, 64'hDEAD_BEEF_0BAD_F00D, 0, 0, 0, 1'b0, 64'h0);

    // Asynchronous reset while a read is outstanding.
    accept_req(2'd0, 2'd0, 4'd3, 64'hFF, t0);
    #2 rst = 1'b1;
    #1;
    check("arst_rd_valid", rd_valid, 0);
    check("arst_state", dbg_state, riscv_v_pkg::IDLE);
    check("arst_req_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_no_result", res_valid, 0);

    // Randomized requests.
    for (int r = 0; r < 24; r++) begin
      logic [1:0] op;
      logic [3:0] n;
      op = 2'($urandom_range(0, 3));
      n  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
      fill_chunks((op == 2'd0) ? 4 : 3);
      run_txn(op, 2'($urandom_range(0, 3)), n, {$urandom, $urandom},
              $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 64'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
